// File: rtl/lights_pkg.sv
// Shared types for the light step scheduler: mode codes, scheduler states,
// default step divider and the demo-sequence helper.
package lights_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_A    = 2'b01,
    MODE_B    = 2'b10,
    MODE_BAD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } sched_state_e;

  localparam int unsigned DIV_DEFAULT        = 8;
  localparam int unsigned DEMO_STEPS_DEFAULT = 4;

  // Demo rotation HOLD -> A -> B -> HOLD.
  function automatic mode_e demo_next(input mode_e m);
    case (m)
      MODE_HOLD: return MODE_A;
      MODE_A:    return MODE_B;
      default:   return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/lights_prescaler.sv
// Step prescaler: counts 0..DIV-1 while enabled, holds while disabled,
// and flags the final count of each step with tick.
import lights_pkg::*;

module lights_prescaler #(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/lights_sched.sv
// Light FSM step scheduler: emits step pulses and applies mode changes only on
// step boundaries. Demo auto-advance is built only with LIGHTS_SCHED_DEMO_EN.
import lights_pkg::*;

module lights_sched #(
  parameter int unsigned DIV        = DIV_DEFAULT,
  parameter int unsigned DEMO_STEPS = DEMO_STEPS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] mode_req,
  input  logic       mode_load,
  input  logic       demo,
  output logic       step_en,
  output logic [1:0] mode_out,
  output logic       pending,
  output logic       err
);

  sched_state_e state_q, state_d;
  mode_e        mode_q, mode_d;
  mode_e        pval_q, pval_d;
  logic         pend_q, pend_d;
  logic         err_q;
  logic         step, load_ok, load_bad, has_pend;

  lights_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .tick  (step)
  );

  assign load_ok  = mode_load && (mode_req != MODE_BAD);
  assign load_bad = mode_load && (mode_req == MODE_BAD);
  // IDLE only records the paused phase; a change accepted while paused lives in pend_q.
  assign has_pend = (state_q == ST_PEND) || ((state_q == ST_IDLE) && pend_q);

`ifdef LIGHTS_SCHED_DEMO_EN
  localparam int unsigned      DCW       = (DEMO_STEPS > 0) ? $clog2(DEMO_STEPS + 1) : 1;
  localparam logic [DCW-1:0]   DEMO_LAST = DCW'(DEMO_STEPS);
  logic [DCW-1:0] dcnt_q, dcnt_d;
`else
  logic demo_unused;
  assign demo_unused = demo | (DEMO_STEPS == 0);
`endif

  always_comb begin
    mode_d = mode_q;
    pval_d = pval_q;
    pend_d = has_pend;
`ifdef LIGHTS_SCHED_DEMO_EN
    dcnt_d = dcnt_q;
    if (load_ok) dcnt_d = '0;
`endif
    if (step) begin
      pend_d = 1'b0;
      // A load landing on the boundary bypasses the pending register.
      if (load_ok) begin
        mode_d = mode_e'(mode_req);
      end else if (has_pend) begin
        mode_d = pval_q;
`ifdef LIGHTS_SCHED_DEMO_EN
        dcnt_d = '0;
`endif
      end
`ifdef LIGHTS_SCHED_DEMO_EN
      else if (demo) begin
        if (dcnt_q == DEMO_LAST) begin
          mode_d = demo_next(mode_q);
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end else begin
        dcnt_d = '0;
      end
`endif
    end else if (load_ok) begin
      pend_d = 1'b1;
      pval_d = mode_e'(mode_req);
    end
    state_d = !run ? ST_IDLE : (pend_d ? ST_PEND : ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      pval_q  <= MODE_HOLD;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LIGHTS_SCHED_DEMO_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      err_q   <= load_bad;
`ifdef LIGHTS_SCHED_DEMO_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign step_en  = step;
  assign mode_out = mode_q;
  assign pending  = pend_q;
  assign err      = err_q;

endmodule
